// File: rtl/tc_input_conditioner.sv
// Input conditioner for the parade traffic-light controller: synchronises and
// debounces sensors/buttons, latches parade requests until acknowledged, and paces the FSM.
module tc_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 50_000_000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic T_A_RAW,
    input  logic T_B_RAW,
    input  logic P_BTN,
    input  logic R_BTN,
    input  logic MODE,
    output logic T_A,
    output logic T_B,
    output logic P,
    output logic R,
    output logic TICK
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam int CH_TA = 0;
    localparam int CH_TB = 1;
    localparam int CH_P  = 2;
    localparam int CH_R  = 3;

    logic [3:0]    w_raw;
    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_d;
    logic [3:0]    r_prev;
    logic [CW-1:0] r_cnt [4];

    logic          w_rise_p;
    logic          w_rise_r;
    logic          r_p;
    logic          r_r;

    logic          r_run;
    logic [TW-1:0] r_pcnt;
    logic          r_tick;

    assign w_raw = {R_BTN, P_BTN, T_B_RAW, T_A_RAW};

    // Synchroniser, debounce and previous-level registers for all four channels.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware chain.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_d    <= '0;
            r_prev <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_prev <= r_d;
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_d[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_d[i]   <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise_p = r_d[CH_P] & ~r_prev[CH_P];
    assign w_rise_r = r_d[CH_R] & ~r_prev[CH_R];

    // Sticky requests; MODE acts as the acknowledge for whichever flag it satisfies.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_p <= 1'b0;
            r_r <= 1'b0;
        end else if (w_rise_p && w_rise_r) begin
            r_p <= 1'b0;
            r_r <= 1'b0;
        end else if (w_rise_p && !MODE) begin
            r_p <= 1'b1;
            r_r <= 1'b0;
        end else if (w_rise_r && MODE) begin
            r_r <= 1'b1;
            r_p <= 1'b0;
        end else if (MODE) begin
            r_p <= 1'b0;
        end else begin
            r_r <= 1'b0;
        end
    end

    // r_run holds the counter for the first edge after reset so the first TICK
    // lands on edge TICK_DIV+1 and TICK stays low on the first edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_run  <= 1'b0;
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_tick <= r_run && (r_pcnt == TW'(TICK_DIV - 1));
            if (r_run) begin
                if (r_pcnt == TW'(TICK_DIV - 1)) begin
                    r_pcnt <= '0;
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end
        end
    end

    assign T_A  = r_d[CH_TA];
    assign T_B  = r_d[CH_TB];
    assign P    = r_p;
    assign R    = r_r;
    assign TICK = r_tick;

endmodule

// File: tb/tb_tc_input_conditioner.sv
// Directed bench for tc_input_conditioner (DEBOUNCE_CYCLES=3, TICK_DIV=5 plus a TICK_DIV=1 copy).
module tb_tc_input_conditioner;

    logic clk;
    logic rst_n;
    logic t_a_raw;
    logic t_b_raw;
    logic p_btn;
    logic r_btn;
    logic mode;

    logic t_a, t_b, p, r, tick;
    logic t_a1, t_b1, p1, r1, tick1;

    int checks;
    int failures;

    tc_input_conditioner #(.DEBOUNCE_CYCLES(3), .TICK_DIV(5)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .T_A_RAW(t_a_raw), .T_B_RAW(t_b_raw), .P_BTN(p_btn), .R_BTN(r_btn), .MODE(mode),
        .T_A(t_a), .T_B(t_b), .P(p), .R(r), .TICK(tick)
    );

    tc_input_conditioner #(.DEBOUNCE_CYCLES(3), .TICK_DIV(1)) dut_div1 (
        .CLK(clk), .RESET_N(rst_n),
        .T_A_RAW(t_a_raw), .T_B_RAW(t_b_raw), .P_BTN(p_btn), .R_BTN(r_btn), .MODE(mode),
        .T_A(t_a1), .T_B(t_b1), .P(p1), .R(r1), .TICK(tick1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_main"}, {27'd0, t_a, t_b, p, r, tick}, 32'd0);
        check({tag, "_div1"}, {27'd0, t_a1, t_b1, p1, r1, tick1}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        t_a_raw  = 1'b0;
        t_b_raw  = 1'b0;
        p_btn    = 1'b0;
        r_btn    = 1'b0;
        mode     = 1'b0;

        #12;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler: edges 6, 11, 16 for TICK_DIV=5; from edge 2 for TICK_DIV=1.
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 1) check_all_zero("first_edge");
            check($sformatf("tick_e%0d", k), tick, (k >= 6) && ((k - 1) % 5 == 0));
            check($sformatf("tick1_e%0d", k), tick1, k >= 2);
        end

        // Sensor debounce: clean rise appears at edge 5.
        t_a_raw = 1'b1;
        t_b_raw = 1'b1;
        step(4);
        check("ta_rise_e4", t_a, 1'b0);
        check("tb_rise_e4", t_b, 1'b0);
        step(1);
        check("ta_rise_e5", t_a, 1'b1);
        check("tb_rise_e5", t_b, 1'b1);
        t_a_raw = 1'b0;
        t_b_raw = 1'b0;
        step(4);
        check("ta_fall_e4", t_a, 1'b1);
        step(1);
        check("ta_fall_e5", t_a, 1'b0);
        check("tb_fall_e5", t_b, 1'b0);
        // Two-cycle glitch must be rejected.
        t_a_raw = 1'b1;
        t_b_raw = 1'b1;
        step(2);
        t_a_raw = 1'b0;
        t_b_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("ta_glitch", t_a, 1'b0);
            check("tb_glitch", t_b, 1'b0);
        end

        // P handshake with MODE=0.
        p_btn = 1'b1;
        step(5);
        check("p_press_e5", p, 1'b0);
        step(1);
        check("p_press_e6", p, 1'b1);
        check("r_idle_e6", r, 1'b0);
        step(10);
        check("p_held", p, 1'b1);
        mode = 1'b1;
        step(1);
        check("p_ack", p, 1'b0);
        p_btn = 1'b0;
        step(6);
        // P press while MODE=1 is ignored.
        p_btn = 1'b1;
        step(8);
        check("p_ignored_mode1", p, 1'b0);
        check("r_after_p_mode1", r, 1'b0);
        p_btn = 1'b0;
        step(6);

        // R handshake with MODE=1.
        r_btn = 1'b1;
        step(5);
        check("r_press_e5", r, 1'b0);
        step(1);
        check("r_press_e6", r, 1'b1);
        mode = 1'b0;
        step(1);
        check("r_ack", r, 1'b0);
        r_btn = 1'b0;
        step(6);

        // MODE=0, P pending: R press ignored.
        p_btn = 1'b1;
        step(6);
        check("p_pending", p, 1'b1);
        p_btn = 1'b0;
        step(6);
        check("p_after_release", p, 1'b1);
        r_btn = 1'b1;
        step(8);
        check("p_kept_on_r", p, 1'b1);
        check("r_ignored_mode0", r, 1'b0);
        r_btn = 1'b0;
        step(6);

        // Simultaneous presses with P pending: both cancelled at edge 6.
        p_btn = 1'b1;
        r_btn = 1'b1;
        step(5);
        check("sim_e5_p", p, 1'b1);
        step(1);
        check("sim_e6_p", p, 1'b0);
        check("sim_e6_r", r, 1'b0);
        p_btn = 1'b0;
        r_btn = 1'b0;
        step(6);

        // MODE=1, R pending: P press leaves R set.
        mode = 1'b1;
        r_btn = 1'b1;
        step(6);
        check("r_pending", r, 1'b1);
        r_btn = 1'b0;
        step(6);
        p_btn = 1'b1;
        step(8);
        check("r_kept_on_p", r, 1'b1);
        check("p_blocked_mode1", p, 1'b0);
        p_btn = 1'b0;
        step(6);
        mode = 1'b0;
        step(1);
        check("r_ack2", r, 1'b0);

        // Reset in the middle of a request and a debounce count.
        p_btn = 1'b1;
        step(6);
        check("p_before_reset", p, 1'b1);
        t_a_raw = 1'b1;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(4);
        check("ta_post_reset_e4", t_a, 1'b0);
        step(1);
        check("p_post_reset_e5", p, 1'b0);
        check("ta_post_reset_e5", t_a, 1'b1);
        step(1);
        check("p_post_reset_e6", p, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
